// File: rtl/exp4_detector_jogada_if.sv
// Button/play bus between the debouncer and the game control unit.
// The master side (the raw buttons and the consumer) drives botoes; the detector drives the rest.
interface exp4_detector_jogada_if;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] jogada_valor;
    logic       multipla;
    logic [2:0] db_estado;

    modport master (
        output botoes,
        input  jogada,
        input  jogada_valor,
        input  multipla,
        input  db_estado
    );

    modport slave (
        input  botoes,
        output jogada,
        output jogada_valor,
        output multipla,
        output db_estado
    );
endinterface

// File: rtl/exp4_detector_jogada.sv
// Synchronises and debounces four play buttons.
// Emits one jogada pulse per clean one-hot press; stable multi-button patterns raise multipla instead.
module exp4_detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input logic                  clock,
    input logic                  reset,
    exp4_detector_jogada_if.slave bus
);
    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        FILTRA_PRESS  = 3'd1,
        GERA_PULSO    = 3'd2,
        AGUARDA_SOLTA = 3'd3,
        FILTRA_SOLTA  = 3'd4
    } estado_t;

    logic [3:0]    sinc_q;
    logic [3:0]    botoes_s_q;
    logic [3:0]    amostra_q;
    logic [3:0]    valor_q;
    logic [CW-1:0] cnt_q;
    logic          multipla_q;
    estado_t       estado_q;
    logic          amostra_onehot;

    // Clearing the lowest set bit leaves zero only for a single-bit pattern.
    assign amostra_onehot = (amostra_q != 4'd0) && ((amostra_q & (amostra_q - 4'd1)) == 4'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q     <= 4'd0;
            botoes_s_q <= 4'd0;
        end else begin
            sinc_q     <= bus.botoes;
            botoes_s_q <= sinc_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            amostra_q  <= 4'd0;
            valor_q    <= 4'd0;
            cnt_q      <= '0;
            multipla_q <= 1'b0;
        end else begin
            multipla_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (botoes_s_q != 4'd0) begin
                        estado_q  <= FILTRA_PRESS;
                        amostra_q <= botoes_s_q;
                        cnt_q     <= '0;
                    end
                end
                FILTRA_PRESS: begin
                    if (botoes_s_q != amostra_q) begin
                        estado_q <= OCIOSO;
                    end else if (cnt_q == CNT_FIM) begin
                        if (amostra_onehot) begin
                            estado_q <= GERA_PULSO;
                            valor_q  <= amostra_q;
                        end else begin
                            estado_q   <= AGUARDA_SOLTA;
                            multipla_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GERA_PULSO: estado_q <= AGUARDA_SOLTA;
                // Pattern changes while held are deliberately ignored; only a full release matters.
                AGUARDA_SOLTA: begin
                    if (botoes_s_q == 4'd0) begin
                        estado_q <= FILTRA_SOLTA;
                        cnt_q    <= '0;
                    end
                end
                FILTRA_SOLTA: begin
                    if (botoes_s_q != 4'd0) begin
                        estado_q <= AGUARDA_SOLTA;
                    end else if (cnt_q == CNT_FIM) begin
                        estado_q <= OCIOSO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign bus.jogada       = (estado_q == GERA_PULSO);
    assign bus.jogada_valor = valor_q;
    assign bus.multipla     = multipla_q;
    assign bus.db_estado    = estado_q;
endmodule

// File: tb/tb_exp4_detector_jogada.sv
// Directed and randomized bench for exp4_detector_jogada with a small debounce window.
// Expected outputs come from a deadline-based reference model of the press/release rules.
module tb_exp4_detector_jogada;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    exp4_detector_jogada_if bus ();

    exp4_detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Reference model: phase follows the press/release rules, deadlines are absolute edge numbers.
    int         m_ph   = 0;
    logic [3:0] m_val  = 4'd0;
    int         m_dead = 0;
    logic [3:0] m_last = 4'd0;
    logic       m_mul  = 1'b0;
    logic [3:0] raw_q[$];

    int n_jog = 0;
    int n_mul = 0;
    int pulse_edge = -1;
    int start;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_val = 4'd0; m_dead = 0; m_last = 4'd0; m_mul = 1'b0;
        raw_q.delete();
        raw_q.push_back(4'd0);
        raw_q.push_back(4'd0);
    endtask

    task automatic model_edge(input logic [3:0] b);
        logic [3:0] v;
        v = raw_q.pop_front();
        raw_q.push_back(b);
        m_mul = 1'b0;
        case (m_ph)
            0: if (v != 4'd0) begin m_ph = 1; m_val = v; m_dead = n + D; end
            1: begin
                if (v != m_val) m_ph = 0;
                else if (n == m_dead) begin
                    if ($countones(m_val) == 1) begin m_ph = 2; m_last = m_val; end
                    else begin m_ph = 3; m_mul = 1'b1; end
                end
            end
            2: m_ph = 3;
            3: if (v == 4'd0) begin m_ph = 4; m_dead = n + D; end
            default: begin
                if (v != 4'd0) m_ph = 3;
                else if (n == m_dead) m_ph = 0;
            end
        endcase
    endtask

    task automatic cycle(input logic [3:0] b);
        bus.botoes = b;
        @(posedge clock);
        n++;
        model_edge(b);
        #1;
        check("jogada", {3'd0, bus.jogada}, {3'd0, (m_ph == 2)});
        check("multipla", {3'd0, bus.multipla}, {3'd0, m_mul});
        check("jogada_valor", bus.jogada_valor, m_last);
        check("db_estado", {1'b0, bus.db_estado}, 4'(m_ph));
        if (bus.jogada) begin n_jog++; pulse_edge = n; end
        if (bus.multipla) n_mul++;
        @(negedge clock);
    endtask

    task automatic hold(input logic [3:0] b, input int len);
        for (int i = 0; i < len; i++) cycle(b);
    endtask

    task automatic clear_counts();
        n_jog = 0; n_mul = 0; pulse_edge = -1;
    endtask

    initial begin
        bus.botoes = 4'd0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("rst_jogada", {3'd0, bus.jogada}, 4'd0);
        check("rst_valor", bus.jogada_valor, 4'd0);
        check("rst_multipla", {3'd0, bus.multipla}, 4'd0);
        check("rst_estado", {1'b0, bus.db_estado}, 4'd0);
        reset = 1'b1;
        hold(4'd0, 3);

        // Clean press with exact latency
        clear_counts(); start = n;
        hold(4'b0100, 20);
        check("t1_pulses", 4'(n_jog), 4'd1);
        check("t1_latency", 4'(pulse_edge - start), 4'd7);
        check("t1_valor", bus.jogada_valor, 4'b0100);

        // Release bounce, then a clean press
        clear_counts();
        hold(4'b0000, 2); hold(4'b0100, 1); hold(4'b0000, 12);
        check("t4_glitch", 4'(n_jog), 4'd0);
        hold(4'b0010, 20); hold(4'b0000, 12);
        check("t4_pulses", 4'(n_jog), 4'd1);
        check("t4_valor", bus.jogada_valor, 4'b0010);

        // Press bounce
        clear_counts();
        hold(4'b0001, 2); hold(4'b0000, 1); hold(4'b0001, 20); hold(4'b0000, 12);
        check("t2_pulses", 4'(n_jog), 4'd1);
        check("t2_valor", bus.jogada_valor, 4'b0001);

        // Multi-press after a prior play
        hold(4'b1000, 20); hold(4'b0000, 12);
        clear_counts();
        hold(4'b0011, 20);
        check("t3_multipla", 4'(n_mul), 4'd1);
        check("t3_jogada", 4'(n_jog), 4'd0);
        check("t3_valor", bus.jogada_valor, 4'b1000);
        hold(4'b0000, 12);

        // Pattern changes while held
        hold(4'b0100, 20);
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            cycle((i < 6) ? 4'b0101 : 4'b0100);
            check("t5_estado", {1'b0, bus.db_estado}, 4'd3);
        end
        check("t5_jogada", 4'(n_jog), 4'd0);
        check("t5_multipla", 4'(n_mul), 4'd0);
        hold(4'b0000, 12);

        // Asynchronous reset during press filtering
        hold(4'b0001, 4);
        check("t6_filtra", {1'b0, bus.db_estado}, 4'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_jogada", {3'd0, bus.jogada}, 4'd0);
        check("t6_valor", bus.jogada_valor, 4'd0);
        check("t6_multipla", {3'd0, bus.multipla}, 4'd0);
        check("t6_estado", {1'b0, bus.db_estado}, 4'd0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); n++; #1;
            check("t6_held", {1'b0, bus.db_estado}, 4'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        clear_counts(); start = n;
        hold(4'b0001, 12);
        check("t6_pulses", 4'(n_jog), 4'd1);
        check("t6_latency", 4'(pulse_edge - start), 4'd7);
        hold(4'b0000, 12);

        // Randomized segments against the model
        begin
            logic [3:0] pat;
            pat = 4'd0;
            for (int s = 0; s < 250; s++) begin
                case ($urandom_range(0, 3))
                    0: pat = 4'd0;
                    1: pat = 4'(1 << $urandom_range(0, 3));
                    2: pat = 4'($urandom_range(0, 15));
                    default: ;
                endcase
                hold(pat, $urandom_range(1, 10));
            end
        end
        hold(4'd0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
